spc7110_dport: RTL



---
 rtl/spc7110_pkg.sv | 31 +++
 rtl/spc7110_dport_fetch.sv | 77 +++++++
 rtl/spc7110_dport.sv | 122 ++++++++++++
 3 files changed

// File: rtl/spc7110_pkg.sv
// rtl/spc7110_pkg.sv - shared offsets, MODE bits, fetch states and helpers for the SPC7110 direct port
package spc7110_pkg;

    localparam logic [3:0] REG_DATA     = 4'h0;
    localparam logic [3:0] REG_PTR_L    = 4'h1;
    localparam logic [3:0] REG_PTR_M    = 4'h2;
    localparam logic [3:0] REG_PTR_H    = 4'h3;
    localparam logic [3:0] REG_ADJ_L    = 4'h4;
    localparam logic [3:0] REG_ADJ_H    = 4'h5;
    localparam logic [3:0] REG_STEP_L   = 4'h6;
    localparam logic [3:0] REG_STEP_H   = 4'h7;
    localparam logic [3:0] REG_MODE     = 4'h8;
    localparam logic [3:0] REG_DATA_ADJ = 4'hA;

    localparam int MODE_INC_STEP = 0;
    localparam int MODE_ADJ      = 1;
    localparam int MODE_SEXT     = 3;

    localparam logic [23:0] DROM_BASE_DEFAULT = 24'h100000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } fetch_state_t;

    function automatic logic [23:0] ext16(input logic [15:0] v, input logic sgn);
        ext16 = {(sgn ? {8{v[15]}} : 8'h00), v};
    endfunction

endpackage

// File: rtl/spc7110_dport_fetch.sv
// rtl/spc7110_dport_fetch.sv - one-byte prefetch FSM with req/ack handshake and redo on retrigger
module spc7110_dport_fetch
    import spc7110_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        i_trig,
    input  logic [23:0] i_addr,
    input  logic        i_ack,
    input  logic [7:0]  i_data,
    output logic        o_req,
    output logic [23:0] o_addr,
    output logic [7:0]  o_buf,
    output logic        o_valid,
    output logic        o_busy
);

    fetch_state_t r_state;
    logic         r_redo;
    logic         r_req;
    logic [23:0]  r_addr;
    logic [7:0]   r_buf;
    logic         r_valid;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_redo  <= 1'b0;
            r_req   <= 1'b0;
            r_addr  <= 24'h0;
            r_buf   <= 8'h00;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_trig) begin
                        r_state <= ST_REQ;
                        r_req   <= 1'b1;
                        r_addr  <= i_addr;
                        r_valid <= 1'b0;
                        r_redo  <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (i_ack) begin
                        r_req <= 1'b0;
                        // Data fetched for a superseded address is dropped.
                        if (r_redo || i_trig) begin
                            r_state <= ST_GAP;
                            r_redo  <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_buf   <= i_data;
                            r_valid <= 1'b1;
                        end
                    end else if (i_trig) begin
                        r_redo <= 1'b1;
                    end
                end
                ST_GAP: begin
                    r_state <= ST_REQ;
                    r_req   <= 1'b1;
                    r_addr  <= i_addr;
                    r_valid <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_req   = r_req;
    assign o_addr  = r_addr;
    assign o_buf   = r_buf;
    assign o_valid = r_valid;
    assign o_busy  = (r_state != ST_IDLE) || i_trig;

endmodule

// File: rtl/spc7110_dport.sv
// rtl/spc7110_dport.sv - $4810-$481A data-ROM direct read port; ADJ feature under SPC7110_DPORT_ADJ_EN
module spc7110_dport
    import spc7110_pkg::*;
#(
    parameter logic [23:0] DROM_BASE = DROM_BASE_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [23:0] ROM_MASK,
    input  logic [3:0]  reg_addr,
    input  logic        reg_we,
    input  logic        reg_re,
    input  logic [7:0]  reg_wdata,
    output logic [7:0]  reg_rdata,
    output logic        rom_rd_req,
    output logic [23:0] rom_rd_addr,
    input  logic        rom_rd_ack,
    input  logic [7:0]  rom_rd_data,
    output logic        busy
);

    logic [23:0] r_ptr;
    logic [15:0] r_adj;
    logic [15:0] r_step;
    logic [7:0]  r_mode;

    logic [23:0] w_ptr_n;
    logic [15:0] w_adj_n;
    logic [15:0] w_step_n;
    logic [7:0]  w_mode_n;
    logic        w_trig;
    logic [23:0] w_eff;
    logic [23:0] w_fetch_addr;
    logic [7:0]  w_buf;
    logic        w_unused_valid;

`ifdef SPC7110_DPORT_ADJ_EN
    localparam logic ADJ_EN = 1'b1;
`else
    localparam logic ADJ_EN = 1'b0;
`endif

    always_comb begin
        w_ptr_n  = r_ptr;
        w_adj_n  = r_adj;
        w_step_n = r_step;
        w_mode_n = r_mode;
        if (reg_re && reg_addr == REG_DATA)
            w_ptr_n = r_ptr + (r_mode[MODE_INC_STEP] ? ext16(r_step, r_mode[MODE_SEXT]) : 24'd1);
        if (ADJ_EN && reg_re && reg_addr == REG_DATA_ADJ)
            w_adj_n = r_adj + r_step;
        // Writes are applied last so they override any auto-increment.
        if (reg_we) begin
            case (reg_addr)
                REG_PTR_L:  w_ptr_n[7:0]   = reg_wdata;
                REG_PTR_M:  w_ptr_n[15:8]  = reg_wdata;
                REG_PTR_H:  w_ptr_n[23:16] = reg_wdata;
                REG_ADJ_L:  if (ADJ_EN) w_adj_n[7:0]  = reg_wdata;
                REG_ADJ_H:  if (ADJ_EN) w_adj_n[15:8] = reg_wdata;
                REG_STEP_L: w_step_n[7:0]  = reg_wdata;
                REG_STEP_H: w_step_n[15:8] = reg_wdata;
                REG_MODE:   w_mode_n       = reg_wdata;
                default:    ;
            endcase
        end
    end

    assign w_trig = (reg_we && (reg_addr == REG_PTR_H || reg_addr == REG_MODE ||
                                (ADJ_EN && reg_addr == REG_ADJ_H))) ||
                    (reg_re && (reg_addr == REG_DATA ||
                                (ADJ_EN && reg_addr == REG_DATA_ADJ)));

    // The fetch address is formed from the post-update register values.
    assign w_eff        = w_ptr_n + ((ADJ_EN && w_mode_n[MODE_ADJ]) ? ext16(w_adj_n, w_mode_n[MODE_SEXT]) : 24'd0);
    assign w_fetch_addr = (w_eff + DROM_BASE) & ROM_MASK;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ptr  <= 24'h0;
            r_adj  <= 16'h0;
            r_step <= 16'h0;
            r_mode <= 8'h00;
        end else begin
            r_ptr  <= w_ptr_n;
            r_adj  <= w_adj_n;
            r_step <= w_step_n;
            r_mode <= w_mode_n;
        end
    end

    always_comb begin
        reg_rdata = 8'h00;
        case (reg_addr)
            REG_DATA:     reg_rdata = w_buf;
            REG_PTR_L:    reg_rdata = r_ptr[7:0];
            REG_PTR_M:    reg_rdata = r_ptr[15:8];
            REG_PTR_H:    reg_rdata = r_ptr[23:16];
            REG_ADJ_L:    reg_rdata = ADJ_EN ? r_adj[7:0] : 8'h00;
            REG_ADJ_H:    reg_rdata = ADJ_EN ? r_adj[15:8] : 8'h00;
            REG_STEP_L:   reg_rdata = r_step[7:0];
            REG_STEP_H:   reg_rdata = r_step[15:8];
            REG_MODE:     reg_rdata = r_mode;
            REG_DATA_ADJ: reg_rdata = ADJ_EN ? w_buf : 8'h00;
            default:      reg_rdata = 8'h00;
        endcase
    end

    spc7110_dport_fetch u_fetch (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .i_trig  (w_trig),
        .i_addr  (w_fetch_addr),
        .i_ack   (rom_rd_ack),
        .i_data  (rom_rd_data),
        .o_req   (rom_rd_req),
        .o_addr  (rom_rd_addr),
        .o_buf   (w_buf),
        .o_valid (w_unused_valid),
        .o_busy  (busy)
    );

endmodule
